// File: rtl/nf10_axis_gearbox_pkg.sv
// Shared definitions for the AXI4-Stream width gearbox: mode selection, lane math and
// tuser field positions.
package nf10_axis_gearbox_pkg;

   typedef enum logic [1:0] {ModePass, ModeUp, ModeDown} mode_e;

   localparam int unsigned TUSER_LEN_POS = 0;

   function automatic mode_e sel_mode(input int unsigned s_w, input int unsigned m_w);
      if (m_w > s_w) return ModeUp;
      if (m_w < s_w) return ModeDown;
      return ModePass;
   endfunction

   function automatic int unsigned ratio(input int unsigned s_w, input int unsigned m_w);
      return (m_w > s_w) ? (m_w / s_w) : (s_w / m_w);
   endfunction

   function automatic int unsigned lane_bits(input int unsigned r);
      return (r > 1) ? $clog2(r) : 1;
   endfunction

   function automatic int unsigned spt_pos(input int unsigned len_w);
      return TUSER_LEN_POS + len_w;
   endfunction

   function automatic int unsigned dpt_pos(input int unsigned len_w, input int unsigned spt_w);
      return TUSER_LEN_POS + len_w + spt_w;
   endfunction

endpackage

// File: rtl/nf10_axis_gearbox_oreg.sv
// One-deep master-side register slice; outputs are pure flops so they hold while stalled.
module nf10_axis_gearbox_oreg #(
   parameter int unsigned DATA_WIDTH  = 256,
   parameter int unsigned TUSER_WIDTH = 128
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   in_tdata,
   input  logic [DATA_WIDTH/8-1:0] in_tstrb,
   input  logic [TUSER_WIDTH-1:0]  in_tuser,
   input  logic                    in_tlast,
   input  logic                    in_tvalid,
   output logic                    in_tready,
   output logic [DATA_WIDTH-1:0]   out_tdata,
   output logic [DATA_WIDTH/8-1:0] out_tstrb,
   output logic [TUSER_WIDTH-1:0]  out_tuser,
   output logic                    out_tlast,
   output logic                    out_tvalid,
   input  logic                    out_tready
);

   assign in_tready = !out_tvalid || out_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_tdata  <= '0;
         out_tstrb  <= '0;
         out_tuser  <= '0;
         out_tlast  <= 1'b0;
         out_tvalid <= 1'b0;
      end else if (in_tready) begin
         out_tvalid <= in_tvalid;
         if (in_tvalid) begin
            out_tdata <= in_tdata;
            out_tstrb <= in_tstrb;
            out_tuser <= in_tuser;
            out_tlast <= in_tlast;
         end
      end
   end

endmodule

// File: rtl/nf10_axis_gearbox.sv
// AXI4-Stream width converter: packs narrow beats into wide ones (UP), splits wide beats
// into narrow ones (DOWN) or register-slices (PASS); all modes share one output slice.
module nf10_axis_gearbox
   import nf10_axis_gearbox_pkg::*;
#(
   parameter int unsigned                C_S_AXIS_DATA_WIDTH    = 64,
   parameter int unsigned                C_M_AXIS_DATA_WIDTH    = 256,
   parameter int unsigned                C_TUSER_WIDTH          = 128,
   parameter int unsigned                C_LEN_WIDTH            = 16,
   parameter int unsigned                C_SPT_WIDTH            = 8,
   parameter int unsigned                C_DPT_WIDTH            = 8,
   parameter int unsigned                C_DEFAULT_VALUE_ENABLE = 0,
   parameter logic [C_SPT_WIDTH-1:0]     C_DEFAULT_SRC_PORT     = '0,
   parameter logic [C_DPT_WIDTH-1:0]     C_DEFAULT_DST_PORT     = '0
) (
   input  logic                             axi_aclk,
   input  logic                             axi_reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic [C_TUSER_WIDTH-1:0]         s_axis_tuser,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic                             s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic [C_TUSER_WIDTH-1:0]         m_axis_tuser,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic [31:0]                      pkt_count
);

   localparam int unsigned S      = C_S_AXIS_DATA_WIDTH;
   localparam int unsigned M      = C_M_AXIS_DATA_WIDTH;
   localparam mode_e       MODE   = sel_mode(S, M);
   localparam int unsigned R      = ratio(S, M);
   localparam int unsigned LW     = lane_bits(R);
   localparam int unsigned SPT_P  = spt_pos(C_LEN_WIDTH);
   localparam int unsigned DPT_P  = dpt_pos(C_LEN_WIDTH, C_SPT_WIDTH);

   logic                     ready_en_q;
   logic                     first_q;
   logic                     s_fire;
   logic [C_TUSER_WIDTH-1:0] beat_user;
   logic [M-1:0]             o_tdata;
   logic [M/8-1:0]           o_tstrb;
   logic [C_TUSER_WIDTH-1:0] o_tuser;
   logic                     o_tlast;
   logic                     o_tvalid;
   logic                     o_tready;

   function automatic logic [C_TUSER_WIDTH-1:0] fix_user(input logic [C_TUSER_WIDTH-1:0] u);
      logic [C_TUSER_WIDTH-1:0] r;
      r = u;
      if (C_DEFAULT_VALUE_ENABLE != 0) begin
         if (u[SPT_P +: C_SPT_WIDTH] == '0) r[SPT_P +: C_SPT_WIDTH] = C_DEFAULT_SRC_PORT;
         if (u[DPT_P +: C_DPT_WIDTH] == '0) r[DPT_P +: C_DPT_WIDTH] = C_DEFAULT_DST_PORT;
      end
      return r;
   endfunction

   // Holds s_axis_tready low until the first edge after reset releases.
   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) ready_en_q <= 1'b0;
      else           ready_en_q <= 1'b1;
   end

   assign s_fire    = s_axis_tvalid && s_axis_tready;
   assign beat_user = first_q ? fix_user(s_axis_tuser) : '0;

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset)   first_q <= 1'b1;
      else if (s_fire) first_q <= s_axis_tlast;
   end

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         pkt_count <= '0;
      end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
         pkt_count <= pkt_count + 32'd1;
      end
   end

   if (MODE == ModePass) begin : g_pass
      assign s_axis_tready = ready_en_q && o_tready;
      assign o_tdata       = s_axis_tdata;
      assign o_tstrb       = s_axis_tstrb;
      assign o_tuser       = beat_user;
      assign o_tlast       = s_axis_tlast;
      assign o_tvalid      = s_fire;
   end else if (MODE == ModeUp) begin : g_up
      logic [LW-1:0]            lane_q;
      logic [M-1:0]             acc_data_q;
      logic [M/8-1:0]           acc_strb_q;
      logic [C_TUSER_WIDTH-1:0] acc_user_q;

      assign s_axis_tready = ready_en_q && o_tready;

      // The completing slave beat is merged combinationally so the master beat is
      // valid the cycle right after it is accepted.
      always_comb begin
         o_tdata = acc_data_q;
         o_tstrb = acc_strb_q;
         o_tdata[lane_q*S +: S]         = s_axis_tdata;
         o_tstrb[lane_q*(S/8) +: (S/8)] = s_axis_tstrb;
         o_tuser  = (lane_q == '0) ? beat_user : acc_user_q;
         o_tlast  = s_axis_tlast;
         o_tvalid = s_fire && ((lane_q == LW'(R - 1)) || s_axis_tlast);
      end

      always_ff @(posedge axi_aclk or posedge axi_reset) begin
         if (axi_reset) begin
            lane_q     <= '0;
            acc_data_q <= '0;
            acc_strb_q <= '0;
            acc_user_q <= '0;
         end else if (s_fire) begin
            if (o_tvalid) begin
               lane_q     <= '0;
               acc_data_q <= '0;
               acc_strb_q <= '0;
               acc_user_q <= '0;
            end else begin
               lane_q     <= lane_q + LW'(1);
               acc_data_q <= o_tdata;
               acc_strb_q <= o_tstrb;
               acc_user_q <= o_tuser;
            end
         end
      end
   end else begin : g_down
      logic [LW-1:0]            lane_q;
      logic [LW-1:0]            next_lane;
      logic                     is_final;
      logic                     push;
      logic [S-1:0]             hold_data_q;
      logic [S/8-1:0]           hold_strb_q;
      logic [C_TUSER_WIDTH-1:0] hold_user_q;
      logic                     hold_last_q;
      logic                     hold_valid_q;

      // Nearest later lane with any strobe set; none means the current lane is final.
      always_comb begin
         next_lane = lane_q;
         is_final  = 1'b1;
         for (int i = R - 1; i >= 1; i--) begin
            if ((i > int'(lane_q)) && (hold_strb_q[i*(M/8) +: (M/8)] != '0)) begin
               next_lane = LW'(i);
               is_final  = 1'b0;
            end
         end
      end

      assign o_tdata       = hold_data_q[lane_q*M +: M];
      assign o_tstrb       = hold_strb_q[lane_q*(M/8) +: (M/8)];
      assign o_tuser       = (lane_q == '0) ? hold_user_q : '0;
      assign o_tlast       = hold_last_q && is_final;
      assign o_tvalid      = hold_valid_q;
      assign push          = hold_valid_q && o_tready;
      assign s_axis_tready = ready_en_q && (!hold_valid_q || (o_tready && is_final));

      always_ff @(posedge axi_aclk or posedge axi_reset) begin
         if (axi_reset) begin
            lane_q       <= '0;
            hold_data_q  <= '0;
            hold_strb_q  <= '0;
            hold_user_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
         end else if (s_fire) begin
            lane_q       <= '0;
            hold_data_q  <= s_axis_tdata;
            hold_strb_q  <= s_axis_tstrb;
            hold_user_q  <= beat_user;
            hold_last_q  <= s_axis_tlast;
            hold_valid_q <= 1'b1;
         end else if (push) begin
            if (is_final) begin
               lane_q       <= '0;
               hold_valid_q <= 1'b0;
            end else begin
               lane_q <= next_lane;
            end
         end
      end
   end

   nf10_axis_gearbox_oreg #(
      .DATA_WIDTH  (M),
      .TUSER_WIDTH (C_TUSER_WIDTH)
   ) u_oreg (
      .clk        (axi_aclk),
      .rst        (axi_reset),
      .in_tdata   (o_tdata),
      .in_tstrb   (o_tstrb),
      .in_tuser   (o_tuser),
      .in_tlast   (o_tlast),
      .in_tvalid  (o_tvalid),
      .in_tready  (o_tready),
      .out_tdata  (m_axis_tdata),
      .out_tstrb  (m_axis_tstrb),
      .out_tuser  (m_axis_tuser),
      .out_tlast  (m_axis_tlast),
      .out_tvalid (m_axis_tvalid),
      .out_tready (m_axis_tready)
   );

endmodule
